// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge detector with one-deep event slots and a round-robin output stage
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] rise_en_i,
    input  logic [NUM_CH-1:0] fall_en_i,
    input  logic [NUM_CH-1:0] ovf_clr_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_rise_o,
    output logic [NUM_CH-1:0] overflow_o
);

    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] r_pend_v;
    logic [NUM_CH-1:0] r_pend_rise;
    logic [NUM_CH-1:0] r_ovf;
    logic              r_out_v;
    logic              r_out_rise;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_rr_ptr;

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] w_qual;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_slot_ld;
    logic              w_load;
    logic              w_found;
    logic [CH_W-1:0]   w_win;
    logic [CH_W-1:0]   w_cand;
    int                w_sum;

    assign w_rise    = a_i & ~r_prev & rise_en_i;
    assign w_fall    = ~a_i & r_prev & fall_en_i;
    assign w_qual    = w_rise | w_fall;
    assign w_load    = ~r_out_v | evt_ready_i;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NUM_CH) begin
                w_sum = w_sum - NUM_CH;
            end
            w_cand = CH_W'(w_sum);
            if (!w_found && r_pend_v[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_grant
        assign w_grant[n] = w_load & w_found & (w_win == CH_W'(n));
    end

    // A slot being granted this cycle is free to take a new edge without overflow.
    assign w_drop    = w_qual & r_pend_v & ~w_grant;
    assign w_slot_ld = w_qual & ~w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= '0;
            r_pend_v    <= '0;
            r_pend_rise <= '0;
            r_ovf       <= '0;
            r_out_v     <= 1'b0;
            r_out_rise  <= 1'b0;
            r_out_ch    <= '0;
            r_rr_ptr    <= CH_W'(NUM_CH - 1);
        end else begin
            r_prev      <= a_i;
            r_pend_v    <= (r_pend_v & ~w_grant) | w_slot_ld;
            r_pend_rise <= (r_pend_rise & ~w_slot_ld) | (w_rise & w_slot_ld);
            r_ovf       <= w_drop | (r_ovf & ~ovf_clr_i);
            if (w_load) begin
                r_out_v <= w_found;
                if (w_found) begin
                    r_out_ch   <= w_win;
                    r_out_rise <= r_pend_rise[w_win];
                    r_rr_ptr   <= w_win;
                end
            end
        end
    end

    assign evt_valid_o = r_out_v;
    assign evt_ch_o    = r_out_ch;
    assign evt_rise_o  = r_out_rise;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - randomized and directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] a_i;
    logic [NUM_CH-1:0] rise_en_i;
    logic [NUM_CH-1:0] fall_en_i;
    logic [NUM_CH-1:0] ovf_clr_i;
    logic              evt_valid_o;
    logic              evt_ready_i;
    logic [CH_W-1:0]   evt_ch_o;
    logic              evt_rise_o;
    logic [NUM_CH-1:0] overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_i         (a_i),
        .rise_en_i   (rise_en_i),
        .fall_en_i   (fall_en_i),
        .ovf_clr_i   (ovf_clr_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ch_o    (evt_ch_o),
        .evt_rise_o  (evt_rise_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-channel pending events, one presented event, last-served channel.
    bit m_prev [NUM_CH];
    bit m_pv   [NUM_CH];
    bit m_pr   [NUM_CH];
    bit m_ovf  [NUM_CH];
    bit m_ov;
    int m_och;
    bit m_orise;
    int m_last;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < NUM_CH; n++) begin
            m_prev[n] = 0; m_pv[n] = 0; m_pr[n] = 0; m_ovf[n] = 0;
        end
        m_ov = 0; m_och = 0; m_orise = 0; m_last = NUM_CH - 1;
    endtask

    task automatic model_step(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] re,
                              input logic [NUM_CH-1:0] fe, input logic [NUM_CH-1:0] clr,
                              input logic rdy);
        int win;
        bit take;
        bit win_rise;
        bit r, f;
        take = !m_ov || rdy;
        win = -1;
        win_rise = 0;
        if (take) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (win < 0 && m_pv[(m_last + k) % NUM_CH]) win = (m_last + k) % NUM_CH;
            end
        end
        if (win >= 0) win_rise = m_pr[win];
        for (int n = 0; n < NUM_CH; n++) begin
            r = a[n] && !m_prev[n] && re[n];
            f = !a[n] && m_prev[n] && fe[n];
            if (r || f) begin
                if (m_pv[n] && win != n) begin
                    m_ovf[n] = 1;
                end else begin
                    m_pv[n] = 1;
                    m_pr[n] = r;
                    if (clr[n]) m_ovf[n] = 0;
                end
            end else begin
                if (win == n) m_pv[n] = 0;
                if (clr[n]) m_ovf[n] = 0;
            end
            m_prev[n] = a[n];
        end
        if (take) begin
            if (win >= 0) begin
                m_ov = 1; m_och = win; m_orise = win_rise; m_last = win;
            end else begin
                m_ov = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; a_i = '0; ovf_clr_i = '0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rise_en_i = '1; fall_en_i = '1; evt_ready_i = 1'b0;
        do_reset();
        n_tests++;
        if ({evt_valid_o, evt_ch_o, evt_rise_o, overflow_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b ch=%0d r=%0b ovf=%b expected all 0",
                     evt_valid_o, evt_ch_o, evt_rise_o, overflow_o);
        end
    endtask

    task automatic test_single();
        rise_en_i = '1; fall_en_i = '1; evt_ready_i = 1'b1;
        do_reset();
        a_i = 4'b0001;
        tick();
        n_tests++;
        if (evt_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_c1: got valid=%0b expected 0", evt_valid_o);
        end
        tick();
        n_tests++;
        if ({evt_valid_o, evt_ch_o, evt_rise_o} !== {1'b1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_c2: got v=%0b ch=%0d r=%0b expected v=1 ch=0 r=1",
                     evt_valid_o, evt_ch_o, evt_rise_o);
        end
        tick();
        n_tests++;
        if (evt_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_c3: got valid=%0b expected 0", evt_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        rise_en_i = '1; fall_en_i = '1; evt_ready_i = 1'b1;
        do_reset();
        a_i = 4'hF;
        tick();
        tick();
        for (int i = 0; i < NUM_CH; i++) begin
            n_tests++;
            if ({evt_valid_o, evt_ch_o, evt_rise_o} !== {1'b1, CH_W'(i), 1'b1}) begin
                n_fail++;
                $display("FAIL burst_%0d: got v=%0b ch=%0d r=%0b expected v=1 ch=%0d r=1",
                         i, evt_valid_o, evt_ch_o, evt_rise_o, i);
            end
            tick();
        end
        n_tests++;
        if (evt_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL burst_end: got valid=%0b expected 0", evt_valid_o);
        end
    endtask

    task automatic test_backpressure();
        rise_en_i = '1; fall_en_i = '1; evt_ready_i = 1'b0;
        do_reset();
        a_i = 4'b0010;
        tick();
        tick();
        a_i = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({evt_valid_o, evt_ch_o, evt_rise_o} !== {1'b1, 2'd1, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got v=%0b ch=%0d r=%0b expected v=1 ch=1 r=1",
                         i, evt_valid_o, evt_ch_o, evt_rise_o);
            end
            tick();
        end
        a_i = 4'b0010;
        tick();
        tick();
        n_tests++;
        if ({evt_valid_o, evt_ch_o, evt_rise_o, overflow_o} !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL bp_overflow: got v=%0b ch=%0d r=%0b ovf=%b expected v=1 ch=1 r=1 ovf=0010",
                     evt_valid_o, evt_ch_o, evt_rise_o, overflow_o);
        end
        evt_ready_i = 1'b1;
        tick();
        n_tests++;
        if ({evt_valid_o, evt_ch_o, evt_rise_o} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_second: got v=%0b ch=%0d r=%0b expected v=1 ch=1 r=0",
                     evt_valid_o, evt_ch_o, evt_rise_o);
        end
        tick();
        n_tests++;
        if (evt_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got valid=%0b expected 0", evt_valid_o);
        end
    endtask

    task automatic test_fall_only();
        int cnt;
        bit bad;
        rise_en_i = 4'b0000; fall_en_i = 4'b0100; evt_ready_i = 1'b1;
        do_reset();
        cnt = 0; bad = 0;
        a_i = 4'b0100;
        tick();
        a_i = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (evt_valid_o) begin
                cnt++;
                if (evt_ch_o !== 2'd2 || evt_rise_o !== 1'b0) bad = 1;
            end
        end
        n_tests++;
        if (cnt != 1 || bad) begin
            n_fail++;
            $display("FAIL fall_only: got %0d events (wrong fields=%0b) expected 1 event ch=2 r=0", cnt, bad);
        end
    endtask

    task automatic test_reset_abort();
        int cnt;
        rise_en_i = '1; fall_en_i = '1; evt_ready_i = 1'b0;
        do_reset();
        a_i = 4'hF;
        tick();
        tick();
        reset = 1'b1; a_i = '0;
        tick();
        reset = 1'b0; evt_ready_i = 1'b1;
        n_tests++;
        if ({evt_valid_o, evt_ch_o, evt_rise_o, overflow_o} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got v=%0b ch=%0d r=%0b ovf=%b expected all 0",
                     evt_valid_o, evt_ch_o, evt_rise_o, overflow_o);
        end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (evt_valid_o) cnt++;
        end
        n_tests++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL abort_quiet: got %0d events expected 0", cnt);
        end
    endtask

    task automatic test_ovf_clear();
        rise_en_i = '1; fall_en_i = '1; evt_ready_i = 1'b0;
        do_reset();
        a_i = 4'b0010;
        tick();
        tick();
        a_i = 4'b0000;
        tick();
        a_i = 4'b0010; ovf_clr_i = 4'b0010;
        tick();
        ovf_clr_i = 4'b0000;
        n_tests++;
        if (overflow_o !== 4'b0010) begin
            n_fail++; $display("FAIL ovf_set_wins: got ovf=%b expected 0010", overflow_o);
        end
        ovf_clr_i = 4'b0010;
        tick();
        ovf_clr_i = 4'b0000;
        n_tests++;
        if (overflow_o !== 4'b0000) begin
            n_fail++; $display("FAIL ovf_clear: got ovf=%b expected 0000", overflow_o);
        end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] ovf_exp;
        logic [NUM_CH-1:0] a_nx;
        do_reset();
        a_nx = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int n = 0; n < NUM_CH; n++) ovf_exp[n] = m_ovf[n];
            n_tests++;
            if (evt_valid_o !== m_ov || overflow_o !== ovf_exp ||
                (m_ov && (evt_ch_o !== CH_W'(m_och) || evt_rise_o !== m_orise))) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got v=%0b ch=%0d r=%0b ovf=%b expected v=%0b ch=%0d r=%0b ovf=%b",
                         cyc, evt_valid_o, evt_ch_o, evt_rise_o, overflow_o,
                         m_ov, m_och, m_orise, ovf_exp);
            end
            a_nx        = a_nx ^ NUM_CH'($urandom & $urandom);
            a_i         = a_nx;
            rise_en_i   = NUM_CH'($urandom | $urandom);
            fall_en_i   = NUM_CH'($urandom | $urandom);
            ovf_clr_i   = NUM_CH'($urandom & $urandom & $urandom);
            evt_ready_i = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
                model_step(a_i, rise_en_i, fall_en_i, ovf_clr_i, evt_ready_i);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; a_i = '0; rise_en_i = '0; fall_en_i = '0;
        ovf_clr_i = '0; evt_ready_i = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fall_only();
        test_reset_abort();
        test_ovf_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: NUM_CH, default 4, number of monitored serial inputs (2..16).
REQ-002 Parameter: CH_W, default log2(NUM_CH) with a minimum of 1, width of the channel index.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_i  input  NUM_CH  per-channel serial inputs; bit n is channel n.
REQ-006 rise_en_i  input  NUM_CH  per-channel rising-edge event enable.
REQ-007 fall_en_i  input  NUM_CH  per-channel falling-edge event enable.
REQ-008 ovf_clr_i  input  NUM_CH  per-channel overflow clear, write-1-to-clear, single-cycle pulse.
REQ-009 evt_valid_o  output  1  event available on the output port.
REQ-010 evt_ready_i  input  1  consumer accepts the event; transfer occurs when evt_valid_o & evt_ready_i.
REQ-011 evt_ch_o  output  CH_W  channel index of the presented event.
REQ-012 evt_rise_o  output  1  1 = rising edge, 0 = falling edge.
REQ-013 overflow_o  output  NUM_CH  sticky per-channel dropped-event flag.

Function
REQ-014 The block SHALL hold one registered copy prev[n] of a_i[n] per channel, updated every cycle.
REQ-015 The block SHALL detect a rising edge on channel n in any cycle where a_i[n]=1 and prev[n]=0, and a falling edge where a_i[n]=0 and prev[n]=1.
REQ-016 A detected edge SHALL be qualified only if the matching enable bit (rise_en_i or fall_en_i) is 1 in the same cycle; unqualified edges are discarded with no side effects.
REQ-017 Each channel SHALL own a one-entry pending slot (valid bit plus type bit); a qualified edge in cycle c SHALL load the slot at the end of cycle c.
REQ-018 The output port SHALL be a registered stage that loads whenever evt_valid_o=0 or a transfer occurs in the current cycle.
REQ-019 When the output stage loads and at least one pending slot is valid, the block SHALL select a channel round-robin, starting from the channel after the last granted channel and wrapping from NUM_CH-1 to 0.
REQ-020 On a load, the winning slot SHALL be moved into evt_ch_o/evt_rise_o with evt_valid_o=1, the slot SHALL be cleared, and the round-robin pointer SHALL be set to the winner.
REQ-021 When the output stage loads and no slot is valid, evt_valid_o SHALL go to 0.
REQ-022 For a qualified edge in cycle c, with an idle output and no competing channels, evt_valid_o SHALL be 1 in cycle c+2.
REQ-023 The output stage SHALL sustain one event per cycle when evt_ready_i is held at 1.
REQ-024 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o, evt_ch_o and evt_rise_o SHALL remain stable.
REQ-025 A qualified edge on a channel whose slot is valid and not being granted in the same cycle SHALL be dropped, the slot SHALL keep its old contents, and overflow_o[n] SHALL set.
REQ-026 A qualified edge on a channel whose slot is granted in the same cycle SHALL load the slot with the new edge, and SHALL NOT set overflow.
REQ-027 ovf_clr_i[n]=1 SHALL clear overflow_o[n] at the end of the cycle; a simultaneous overflow set on channel n SHALL take priority.
REQ-028 Deasserting an enable SHALL NOT flush an already pending or presented event.

Reset
REQ-029 While reset=1 at posedge clk, prev, all pending slots and overflow_o SHALL clear to 0, evt_valid_o, evt_ch_o and evt_rise_o SHALL be 0, and the round-robin pointer SHALL be NUM_CH-1 (channel 0 has first priority).
REQ-030 Reset SHALL abort any presented or pending event without a transfer, regardless of evt_ready_i.
REQ-031 Because prev resets to 0, a_i[n]=1 with rise_en_i[n]=1 in the first cycle after reset SHALL produce a rising event.

Verification
REQ-032 Reset with a_i=0 and all enables 1, raise a_i[0] in cycle c, ready=1 -> evt_valid_o=1, ch=0, rise=1 in c+2 only.
REQ-033 Raise a_i[3:0] in the same cycle, ready=1 -> four consecutive events with ch=0,1,2,3, each with rise=1, then valid=0.
REQ-034 ready=0; on ch1 rise, then fall, then rise, each 2 cycles apart -> output holds ch1/rise stable; fall is pending; the third edge sets overflow_o[1]=1; after ready=1 the bench sees exactly rise then fall.
REQ-035 fall_en_i[2]=1, rise_en_i[2]=0, pulse a_i[2] 0->1->0 -> exactly one event with ch=2, rise=0.
REQ-036 Reset asserted for 1 cycle while evt_valid_o=1 with slots pending, a_i=0 -> all outputs are 0 the next cycle and no events appear afterwards.
REQ-037 ovf_clr_i[1]=1 in the same cycle as a new overflow on ch1 -> overflow_o[1] stays 1; a clear in a later cycle with no overflow -> 0.
